// File: rtl/ddr_frame_writer.sv
// ============================================================================
// ddr_frame_writer
//
// Packs a 32-bit video word stream into fixed-length AXI4 INCR write bursts.
// The bursts go into one of two ping-pong frame buffers in DDR. Each finished
// frame is handed to the downstream DDR reader through the ddr_read_start
// handshake, and odd_even_flag names the buffer that holds it. The
// ddr_read_finish handshake tells this block when the reader has released its
// buffer. If the reader is still busy when a frame completes, the frame is
// dropped (frame_skip), and the next frame overwrites the same buffer.
//
// Optional feature (macro WR_ERR_CNT_EN): adds output wr_err_cnt, a
// saturating count of write responses with BRESP != OKAY.
//
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   pix_data/valid/sof    input word stream; pix_sof marks the first word
//   pix_ready             input stream backpressure
//   M_AXI_AW*             write address channel (fixed INCR burst attributes)
//   M_AXI_W*              write data channel
//   M_AXI_B*              write response channel
//   ddr_read_start*       publish handshake to the reader, plus odd_even_flag
//   ddr_read_finish*      release handshake from the reader
//   frame_skip            one-cycle pulse when a finished frame is dropped
//   wr_err_cnt            (WR_ERR_CNT_EN only) error response counter
// ============================================================================
module ddr_frame_writer #(
    parameter logic [31:0] BUF0_BASE   = 32'h2BC0_0000,
    parameter logic [31:0] BUF1_BASE   = 32'h2BE0_0000,
    parameter int          BURST_LEN   = 16,
    parameter int          FRAME_WORDS = 153600
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [31:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic [31:0] M_AXI_AWADDR,
    output logic [7:0]  M_AXI_AWLEN,
    output logic [2:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic [3:0]  M_AXI_AWCACHE,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WLAST,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic        ddr_read_start,
    output logic        ddr_read_start_valid,
    input  logic        ddr_read_start_ready,
    output logic        odd_even_flag,
    input  logic        ddr_read_finish,
    input  logic        ddr_read_finish_valid,
    output logic        ddr_read_finish_ready,
    output logic        frame_skip
`ifdef WR_ERR_CNT_EN
    ,
    output logic [15:0] wr_err_cnt
`endif
);

    localparam int DEPTH  = 2 * BURST_LEN;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BURSTS = FRAME_WORDS / BURST_LEN;

    localparam logic [31:0]      ADDR_STEP  = 32'(BURST_LEN * 4);
    localparam logic [7:0]       LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [31:0]      LAST_BURST = 32'(BURSTS - 1);
    localparam logic [CNT_W-1:0] FILL_LEVEL = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP, DONE} state_t;

    state_t state, next_state;

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_push, fifo_pop;

    logic [31:0] addr;
    logic [31:0] burst_cnt;
    logic [7:0]  beat_cnt;
    logic        wr_buf, rd_busy, start_valid, oe_flag;
    logic        finish_hs, busy_eff, publish, last_beat, last_burst, b_hs;

    assign fifo_full  = (fifo_count == FULL_LEVEL);
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign last_burst = (burst_cnt == LAST_BURST);
    assign b_hs       = (state == RESP) && M_AXI_BVALID;

    // In IDLE the stream is drained, but only the SOF word is stored. A full
    // FIFO must never be written, even in IDLE.
    assign fifo_push = pix_valid && pix_ready && !fifo_full &&
                       ((state != IDLE) || pix_sof);
    assign fifo_pop  = (state == DATA) && M_AXI_WREADY;

    // A finish in the DONE cycle releases the reader before the publish
    // decision, so that frame is still published.
    assign finish_hs = ddr_read_finish_valid && ddr_read_finish;
    assign busy_eff  = rd_busy && !finish_hs;
    assign publish   = (state == DONE) && !busy_eff;

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (pix_valid && pix_sof)          next_state = FILL;
            FILL: if (fifo_count >= FILL_LEVEL)      next_state = ADDR;
            ADDR: if (M_AXI_AWREADY)                 next_state = DATA;
            DATA: if (M_AXI_WREADY && last_beat)     next_state = RESP;
            RESP: if (M_AXI_BVALID)                  next_state = last_burst ? DONE : FILL;
            DONE:                                    next_state = IDLE;
            default:                                 next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pix_ready             = (state == IDLE) ? 1'b1 : !fifo_full;
        M_AXI_AWADDR          = addr;
        M_AXI_AWLEN           = LAST_BEAT;
        M_AXI_AWSIZE          = 3'b010;
        M_AXI_AWBURST         = 2'b01;
        M_AXI_AWCACHE         = 4'b0011;
        M_AXI_AWPROT          = 3'b000;
        M_AXI_AWVALID         = (state == ADDR);
        M_AXI_WSTRB           = 4'hF;
        M_AXI_WVALID          = (state == DATA);
        M_AXI_WDATA           = (state == DATA) ? fifo_mem[rd_ptr] : 32'd0;
        M_AXI_WLAST           = (state == DATA) && last_beat;
        M_AXI_BREADY          = (state == RESP);
        ddr_read_start        = start_valid;
        ddr_read_start_valid  = start_valid;
        odd_even_flag         = oe_flag;
        ddr_read_finish_ready = 1'b1;
        frame_skip            = (state == DONE) && busy_eff;
    end

    // FIFO storage. It has no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= pix_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Burst address, burst and beat counters
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            addr      <= '0;
            burst_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (state == IDLE && pix_valid && pix_sof) begin
                addr      <= wr_buf ? BUF1_BASE : BUF0_BASE;
                burst_cnt <= '0;
            end else if (b_hs) begin
                addr      <= addr + ADDR_STEP;
                burst_cnt <= burst_cnt + 32'd1;
            end
            if (fifo_pop) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    // Ping-pong buffer selection and the publish/release handshakes
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_buf      <= 1'b0;
            rd_busy     <= 1'b0;
            start_valid <= 1'b0;
            oe_flag     <= 1'b0;
        end else if (publish) begin
            wr_buf      <= !wr_buf;
            rd_busy     <= 1'b1;
            start_valid <= 1'b1;
            oe_flag     <= wr_buf;
        end else begin
            if (finish_hs)                          rd_busy     <= 1'b0;
            if (start_valid && ddr_read_start_ready) start_valid <= 1'b0;
        end
    end

`ifdef WR_ERR_CNT_EN
    // Saturating count of error responses
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            wr_err_cnt <= 16'd0;
        else if (b_hs && (M_AXI_BRESP != 2'b00) && (wr_err_cnt != 16'hFFFF))
            wr_err_cnt <= wr_err_cnt + 16'd1;
    end
`else
    logic bresp_unused;
    assign bresp_unused = ^M_AXI_BRESP;
`endif

endmodule
